prefix_addsub_seq: RTL

- Iterative parallel-prefix adder/subtractor; it consumes the generate/propagate combine operation that the tree nodes produce.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Resolves one Kogge-Stone prefix level per clock, then holds the registered result until the consumer takes it.
- Sits between the operand source and result sink in the adder datapath; gives a low-area, multi-cycle alternative to the fully combinational prefix tree.

---
 rtl/prefix_addsub_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/prefix_addsub_seq.sv
// rtl/prefix_addsub_seq.sv - iterative Kogge-Stone adder/subtractor, one prefix level per clock; PREFIX_ADDSUB_BACK2BACK_EN enables accept-on-handshake in DONE
module prefix_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int KW     = $clog2(LEVELS + 1);
  // k reaches LEVELS in the final SCAN cycle, where the carries are complete
  localparam logic [KW-1:0] K_LAST = KW'(LEVELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] g_q, p_q, p0_q;
  logic             cin_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, ovf_q;

  logic [WIDTH-1:0] bb, p_init, g_init;
  logic [WIDTH-1:0] g_lvl, p_lvl;
  logic [WIDTH-1:0] carries;
  logic             accept, last_level;

`ifdef PREFIX_ADDSUB_BACK2BACK_EN
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept     = in_valid && in_ready;
  assign last_level = (state_q == SCAN) && (k_q == K_LAST);
  assign out_valid  = (state_q == DONE);
  assign sum        = sum_q;
  assign carry_out  = carry_q;
  assign overflow   = ovf_q;

  // Initial generate/propagate; carry-in folds into bit 0's generate
  always_comb begin
    bb        = b ^ {WIDTH{sub}};
    p_init    = a ^ bb;
    g_init    = a & bb;
    g_init[0] = (a[0] & bb[0]) | (p_init[0] & sub);
  end

  // One Kogge-Stone level at distance 2^k; bits below the distance pass through
  always_comb begin
    g_lvl = g_q;
    p_lvl = p_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= (1 << k_q)) begin
        g_lvl[i] = g_q[i] | (p_q[i] & g_q[i - (1 << k_q)]);
        p_lvl[i] = p_q[i] & p_q[i - (1 << k_q)];
      end
    end
  end

  // Carry into each bit: cin for bit 0, prefix generate of the bit below otherwise
  always_comb begin
    carries = {g_q[WIDTH-2:0], cin_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SCAN;
      end
      SCAN: begin
        if (last_level) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = accept ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, prefix iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      g_q     <= '0;
      p_q     <= '0;
      p0_q    <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      k_q   <= '0;
      g_q   <= g_init;
      p_q   <= p_init;
      p0_q  <= p_init;
      cin_q <= sub;
    end else if (last_level) begin
      sum_q   <= p0_q ^ carries;
      carry_q <= g_q[WIDTH-1];
      ovf_q   <= g_q[WIDTH-1] ^ g_q[WIDTH-2];
    end else if (state_q == SCAN) begin
      g_q <= g_lvl;
      p_q <= p_lvl;
      k_q <= k_q + 1'b1;
    end
  end

endmodule
